// File: rtl/seq_mul_ctrl.sv
// Sequential unsigned shift-and-add multiplier.
// One N-bit ripple-carry adder is reused over N iterations to build a 2N-bit
// product behind a start/busy/done handshake.

// N-bit ripple-carry adder with carry-out; the only adder in the multiplier.
module seq_mul_adder #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum,
    output logic         cout
);
    logic [N:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[N];
endmodule

module seq_mul_ctrl #(
    parameter int N  = 32,
    parameter int CW = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Count value seen on the final RUN cycle.
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [1:0]    state;
    logic [N-1:0]  acc;      // A: upper half of the running product
    logic [N-1:0]  mq;       // Q: multiplier bits, shifted out LSB first
    logic [N-1:0]  mcand;    // M
    logic [CW-1:0] count;

    logic [N-1:0]  addend;
    logic [N-1:0]  acc_sum;
    logic          carry;
    logic [N-1:0]  acc_nxt;
    logic [N-1:0]  mq_nxt;

    // Add M only when the current multiplier LSB is set.
    assign addend = mq[0] ? mcand : '0;

    seq_mul_adder #(.N(N)) u_add (
        .a    (acc),
        .b    (addend),
        .sum  (acc_sum),
        .cout (carry)
    );

    // {C, A_sum, Q} shifted right by one: the carry lands in A's MSB and the
    // bit falling out of A becomes Q's MSB, so no carry is ever lost.
    assign acc_nxt = {carry, acc_sum[N-1:1]};
    assign mq_nxt  = {acc_sum[0], mq[N-1:1]};

    // Control FSM, datapath registers and the product register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            acc     <= '0;
            mq      <= '0;
            mcand   <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc   <= '0;
                        mq    <= multiplier;
                        mcand <= multiplicand;
                        count <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc   <= acc_nxt;
                    mq    <= mq_nxt;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        product <= {acc_nxt, mq_nxt};
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Status outputs come straight off the state register.
    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);
endmodule

// File: tb/tb_seq_mul_ctrl.sv
// Directed bench for seq_mul_ctrl: a 32-bit instance for the arithmetic,
// latency and reset cases and a 4-bit instance for back-to-back starts.
module tb_seq_mul_ctrl;
    logic        clk = 1'b0;
    logic        rst;

    logic        start;
    logic [31:0] mc, mp;
    logic        busy, done;
    logic [63:0] product;

    logic        start4;
    logic [3:0]  mc4, mp4;
    logic        busy4, done4;
    logic [7:0]  product4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_mul_ctrl #(.N(32), .CW(6)) dut (
        .clk(clk), .rst(rst), .start(start),
        .multiplicand(mc), .multiplier(mp),
        .busy(busy), .done(done), .product(product)
    );

    seq_mul_ctrl #(.N(4), .CW(3)) dut4 (
        .clk(clk), .rst(rst), .start(start4),
        .multiplicand(mc4), .multiplier(mp4),
        .busy(busy4), .done(done4), .product(product4)
    );

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mc = '0; mp = '0;
        start4 = 1'b0; mc4 = '0; mp4 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0) begin
            errors++;
            $display("FAIL reset32 busy=%b done=%b product=%h want 0 0 0", busy, done, product);
        end
        checks++;
        if (busy4 !== 1'b0 || done4 !== 1'b0 || product4 !== 8'd0) begin
            errors++;
            $display("FAIL reset4 busy=%b done=%b product=%h want 0 0 0", busy4, done4, product4);
        end
        rst = 1'b0;
    endtask

    // One multiply on the 32-bit instance. n counts falling edges after the
    // accepting clock edge; done is expected at n == 32 and only there.
    // With poke set, a second start and new operands arrive mid-RUN.
    task automatic run32(input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input logic [63:0] prev,
                         input bit poke, input string nm);
        int n, busy_cnt, done_cnt, done_at;
        @(negedge clk);
        start = 1'b1; mc = a; mp = b;
        @(negedge clk);
        start = 1'b0; mc = $urandom; mp = $urandom;
        n = 0; busy_cnt = 0; done_cnt = 0; done_at = -1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_start got %b want 1", nm, busy);
        end
        while (n < 40) begin
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = n;
                    checks++;
                    if (product !== exp) begin
                        errors++;
                        $display("FAIL %s product got %h want %h", nm, product, exp);
                    end
                end
            end
            if (n == 16) begin
                checks++;
                if (product !== prev) begin
                    errors++;
                    $display("FAIL %s hold_during_run got %h want %h", nm, product, prev);
                end
            end
            if (poke && n == 5) begin start = 1'b1; mc = 32'd3; mp = 32'd3; end
            if (poke && n == 6) begin start = 1'b0; mc = 32'hdeadbeef; mp = 32'h0badf00d; end
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_at != 32) begin
            errors++;
            $display("FAIL %s latency got %0d want 32", nm, done_at);
        end
        checks++;
        if (busy_cnt != 32 || done_cnt != 1) begin
            errors++;
            $display("FAIL %s busy_cycles=%0d done_pulses=%0d want 32 1", nm, busy_cnt, done_cnt);
        end
        checks++;
        if (product !== exp || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s held_after product=%h busy=%b want %h 0", nm, product, busy, exp);
        end
    endtask

    task automatic test_basic();
        run32(32'd100, 32'd200, 64'h0000000000004E20, 64'd0, 1'b0, "basic");
    endtask

    task automatic test_carry();
        run32(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 64'h4E20, 1'b0, "carry");
    endtask

    task automatic test_zero();
        run32(32'd0, 32'h12345678, 64'd0, 64'hFFFFFFFE00000001, 1'b0, "zero_m");
        run32(32'h12345678, 32'd0, 64'd0, 64'd0, 1'b0, "zero_q");
    endtask

    task automatic test_ignore_start();
        run32(32'd7, 32'd9, 64'd63, 64'd0, 1'b1, "ignore_start");
    endtask

    task automatic test_reset_mid();
        int seen_done, seen_busy;
        @(negedge clk);
        start = 1'b1; mc = 32'd1000; mp = 32'd1000;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0) begin
            errors++;
            $display("FAIL reset_mid busy=%b done=%b product=%h want 0 0 0", busy, done, product);
        end
        seen_done = 0; seen_busy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen_done++;
            if (busy === 1'b1) seen_busy++;
        end
        checks++;
        if (seen_done != 0 || seen_busy != 0) begin
            errors++;
            $display("FAIL reset_mid_quiet done_pulses=%0d busy_cycles=%0d want 0 0", seen_done, seen_busy);
        end
        run32(32'd5, 32'd6, 64'd30, 64'd0, 1'b0, "after_reset");
    endtask

    // start held high on the 4-bit instance. Each op spends one IDLE cycle,
    // four RUN cycles and one DONE cycle, so done repeats every 6 edges.
    task automatic test_back_to_back();
        int n, first_at, second_at, done_cnt;
        @(negedge clk);
        start4 = 1'b1; mc4 = 4'd15; mp4 = 4'd15;
        @(negedge clk);
        n = 0; first_at = -1; second_at = -1; done_cnt = 0;
        while (n < 20) begin
            if (done4 === 1'b1) begin
                done_cnt++;
                if (first_at < 0) begin
                    first_at = n;
                    checks++;
                    if (product4 !== 8'd225) begin
                        errors++;
                        $display("FAIL b2b_first product got %0d want 225", product4);
                    end
                    mc4 = 4'd2; mp4 = 4'd3;
                end else if (second_at < 0) begin
                    second_at = n;
                    checks++;
                    if (product4 !== 8'd6) begin
                        errors++;
                        $display("FAIL b2b_second product got %0d want 6", product4);
                    end
                    start4 = 1'b0;
                end
            end
            if (first_at >= 0 && n == first_at + 1) begin
                checks++;
                if (busy4 !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_idle_gap busy got %b want 0", busy4);
                end
            end
            if (first_at >= 0 && n == first_at + 2) begin
                checks++;
                if (busy4 !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_retrigger busy got %b want 1", busy4);
                end
            end
            @(negedge clk);
            n++;
        end
        checks++;
        if (first_at != 4 || second_at != 10 || done_cnt != 2) begin
            errors++;
            $display("FAIL b2b_timing first=%0d second=%0d pulses=%0d want 4 10 2",
                     first_at, second_at, done_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_zero();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
